// File: rtl/delayed_operand_stage_pkg.sv
// cpu_defs: shared types for the delayed-operand stage (fwd ports, exec bundle, FSM states).
package cpu_defs;
    localparam int XLEN = 32;
    typedef struct packed {
        logic            we;
        logic [4:0]      waddr;
        logic [XLEN-1:0] wdata;
    } fwd_port_t;
    typedef struct packed {
        logic       delayed_exec;
        logic [3:0] op;
        logic [4:0] rd;
    } decoded_t;
    typedef struct packed {
        decoded_t             decoded;
        logic [XLEN-1:0]      pc;
        logic [1:0][XLEN-1:0] delayed_reg;
    } pipeline_exec_t;
    typedef enum logic [1:0] {EMPTY, WAIT, HOLD} delayed_operand_state_t;
endpackage

// File: rtl/delayed_operand_stage_if.sv
// delayed_operand_stage_if: upstream/forwarding/downstream signals of the delayed-operand stage.
interface delayed_operand_stage_if import cpu_defs::*; #(parameter int FWD_PORTS = 2);
    logic                      flush;
    logic                      stall;
    logic                      in_valid;
    pipeline_exec_t            data_in;
    logic [1:0][4:0]           src_addr;
    logic [1:0]                src_ready;
    fwd_port_t [FWD_PORTS-1:0] fwd;
    logic                      out_valid;
    pipeline_exec_t            data_out;
    logic                      stall_req;
    logic [31:0]               wait_cycles;
    modport master (
        output flush, stall, in_valid, data_in, src_addr, src_ready, fwd,
        input  out_valid, data_out, stall_req, wait_cycles
    );
    modport slave (
        input  flush, stall, in_valid, data_in, src_addr, src_ready, fwd,
        output out_valid, data_out, stall_req, wait_cycles
    );
endinterface

// File: rtl/delayed_operand_stage_bypass_mux.sv
// delayed_bypass_mux: priority select of one operand over the writeback ports; register 0 never hits.
module delayed_bypass_mux import cpu_defs::*; #(parameter int FWD_PORTS = 2) (
    input  logic [4:0]                addr,
    input  fwd_port_t [FWD_PORTS-1:0] fwd,
    output logic                      zero,
    output logic                      hit,
    output logic [XLEN-1:0]           wdata
);
    assign zero = addr == 5'd0;
    always_comb begin
        hit   = 1'b0;
        wdata = '0;
        // ascending scan so the youngest (highest-index) port overrides
        for (int p = 0; p < FWD_PORTS; p++)
            if (fwd[p].we && fwd[p].waddr == addr && !zero) begin
                hit   = 1'b1;
                wdata = fwd[p].wdata;
            end
    end
endmodule

// File: rtl/delayed_operand_stage.sv
// delayed_operand_stage: holds one delayed-exec instruction until both operands are resolved.
// Optional DELAYED_OPERAND_PERF_EN adds a saturating WAIT-cycle counter on wait_cycles.
module delayed_operand_stage import cpu_defs::*; #(parameter int FWD_PORTS = 2) (
    input logic                   clk,
    input logic                   rst_n,
    delayed_operand_stage_if.slave bus
);
    delayed_operand_state_t state, state_n;
    pipeline_exec_t         entry, entry_n;
    logic [1:0]             rdy, rdy_n;
    logic [1:0][4:0]        addr_q, addr_n, sel_addr;
    logic [1:0]             zero, hit;
    logic [1:0][XLEN-1:0]   wdata;
    logic                   cap;

    // the stored addresses are only watched while waiting; otherwise the incoming ones
    assign sel_addr = (state == WAIT) ? addr_q : bus.src_addr;

    for (genvar i = 0; i < 2; i++) begin : g_mux
        delayed_bypass_mux #(.FWD_PORTS(FWD_PORTS)) u_mux (
            .addr  (sel_addr[i]),
            .fwd   (bus.fwd),
            .zero  (zero[i]),
            .hit   (hit[i]),
            .wdata (wdata[i])
        );
    end

    assign bus.out_valid = state == HOLD;
    assign bus.stall_req = state == WAIT;
    assign cap = bus.in_valid && !bus.stall && !bus.stall_req && !bus.flush;

    always_comb begin
        state_n = state;
        entry_n = entry;
        rdy_n   = rdy;
        addr_n  = addr_q;
        if (bus.flush) begin
            state_n = EMPTY;
            rdy_n   = '0;
        end else if (cap) begin
            entry_n = bus.data_in;
            addr_n  = bus.src_addr;
            for (int i = 0; i < 2; i++) begin
                entry_n.delayed_reg[i] = zero[i] ? '0 : bus.src_ready[i] ? bus.data_in.delayed_reg[i] : wdata[i];
                rdy_n[i] = zero[i] || bus.src_ready[i] || hit[i];
            end
            state_n = &rdy_n ? HOLD : WAIT;
        end else if (state == WAIT) begin
            for (int i = 0; i < 2; i++)
                if (!rdy[i] && hit[i]) begin
                    entry_n.delayed_reg[i] = wdata[i];
                    rdy_n[i] = 1'b1;
                end
            state_n = &rdy_n ? HOLD : WAIT;
        end else if (state == HOLD && !bus.stall) begin
            state_n = EMPTY;
            rdy_n   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            entry  <= '0;
            rdy    <= '0;
            addr_q <= '0;
        end else begin
            state  <= state_n;
            entry  <= entry_n;
            rdy    <= rdy_n;
            addr_q <= addr_n;
        end
    end

    always_comb begin
        bus.data_out = entry;
        bus.data_out.decoded.delayed_exec = bus.out_valid;
    end

`ifdef DELAYED_OPERAND_PERF_EN
    logic [31:0] wait_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= '0;
        else if (state == WAIT && wait_cnt != '1) wait_cnt <= wait_cnt + 32'd1;
    end
    assign bus.wait_cycles = wait_cnt;
`else
    assign bus.wait_cycles = '0;
`endif
endmodule

// File: tb/tb_delayed_operand_stage.sv
// tb_delayed_operand_stage: directed vectors with hand-computed expectations for the delayed-operand stage.
module tb_delayed_operand_stage;
    import cpu_defs::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    delayed_operand_stage_if #(.FWD_PORTS(2)) bus ();
    delayed_operand_stage #(.FWD_PORTS(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] rdy, input logic [4:0] a0, input logic [4:0] a1,
                           input logic [31:0] r0, input logic [31:0] r1);
        bus.in_valid = 1'b1;
        bus.data_in = '0;
        bus.data_in.pc = 32'h100;
        bus.data_in.delayed_reg[0] = r0;
        bus.data_in.delayed_reg[1] = r1;
        bus.src_addr[0] = a0;
        bus.src_addr[1] = a1;
        bus.src_ready = rdy;
    endtask

    initial begin
        logic [31:0] exp_wait;
`ifdef DELAYED_OPERAND_PERF_EN
        exp_wait = 32'd2;
`else
        exp_wait = 32'd0;
`endif
        bus.flush = 0; bus.stall = 0; bus.in_valid = 0; bus.data_in = '0;
        bus.src_addr = '0; bus.src_ready = '0; bus.fwd = '0;
        #2;
        chk("rst_ov", bus.out_valid, 0);
        chk("rst_sr", bus.stall_req, 0);
        chk("rst_do", |bus.data_out, 0);
        chk("rst_wc", bus.wait_cycles, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        present(2'b11, 5'd3, 5'd4, 32'd5, 32'd7);
        tick();
        bus.in_valid = 0;
        chk("rdy_ov", bus.out_valid, 1);
        chk("rdy_r0", bus.data_out.delayed_reg[0], 5);
        chk("rdy_r1", bus.data_out.delayed_reg[1], 7);
        chk("rdy_sr", bus.stall_req, 0);
        chk("rdy_dx", bus.data_out.decoded.delayed_exec, 1);
        tick();
        chk("rdy_drain", bus.out_valid, 0);

        present(2'b01, 5'd3, 5'd9, 32'h11, 32'h0);
        tick();
        bus.in_valid = 0;
        chk("wt_sr1", bus.stall_req, 1);
        chk("wt_ov1", bus.out_valid, 0);
        tick();
        chk("wt_sr2", bus.stall_req, 1);
        bus.fwd[0] = '{we: 1'b1, waddr: 5'd9, wdata: 32'h1234};
        tick();
        bus.fwd = '0;
        chk("wt_ov", bus.out_valid, 1);
        chk("wt_sr3", bus.stall_req, 0);
        chk("wt_r1", bus.data_out.delayed_reg[1], 32'h1234);
        chk("wt_r0", bus.data_out.delayed_reg[0], 32'h11);
        chk("wt_cnt", bus.wait_cycles, exp_wait);
        tick();

        present(2'b01, 5'd3, 5'd9, 32'h11, 32'h0);
        tick();
        bus.in_valid = 0;
        bus.fwd[0] = '{we: 1'b1, waddr: 5'd9, wdata: 32'hAAAA};
        bus.fwd[1] = '{we: 1'b1, waddr: 5'd9, wdata: 32'hBBBB};
        tick();
        bus.fwd = '0;
        chk("prio_ov", bus.out_valid, 1);
        chk("prio_r1", bus.data_out.delayed_reg[1], 32'hBBBB);
        tick();

        present(2'b11, 5'd1, 5'd2, 32'h21, 32'h22);
        tick();
        present(2'b11, 5'd1, 5'd2, 32'h31, 32'h32);
        bus.stall = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stl_ov", bus.out_valid, 1);
            chk("stl_r0", bus.data_out.delayed_reg[0], 32'h21);
        end
        bus.stall = 0;
        tick();
        bus.in_valid = 0;
        chk("stl_new_ov", bus.out_valid, 1);
        chk("stl_new_r0", bus.data_out.delayed_reg[0], 32'h31);
        tick();
        chk("stl_drain", bus.out_valid, 0);

        present(2'b01, 5'd3, 5'd9, 32'h11, 32'h0);
        tick();
        bus.in_valid = 0;
        chk("fl_sr_pre", bus.stall_req, 1);
        bus.flush = 1;
        bus.fwd[0] = '{we: 1'b1, waddr: 5'd9, wdata: 32'h55};
        tick();
        bus.flush = 0;
        bus.fwd = '0;
        chk("fl_ov", bus.out_valid, 0);
        chk("fl_sr", bus.stall_req, 0);
        tick();
        chk("fl_ov2", bus.out_valid, 0);

        present(2'b01, 5'd3, 5'd12, 32'h44, 32'h0);
        bus.fwd[1] = '{we: 1'b1, waddr: 5'd12, wdata: 32'hCAFE};
        tick();
        bus.in_valid = 0;
        bus.fwd = '0;
        chk("capfwd_ov", bus.out_valid, 1);
        chk("capfwd_r1", bus.data_out.delayed_reg[1], 32'hCAFE);
        tick();

        present(2'b10, 5'd0, 5'd5, 32'hDEAD, 32'h77);
        tick();
        bus.in_valid = 0;
        chk("z_ov", bus.out_valid, 1);
        chk("z_r0", bus.data_out.delayed_reg[0], 0);
        chk("z_r1", bus.data_out.delayed_reg[1], 32'h77);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ov", bus.out_valid, 0);
        chk("arst_do", |bus.data_out, 0);
        chk("arst_sr", bus.stall_req, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_ov", bus.out_valid, 0);
        chk("rel_sr", bus.stall_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/delayed_operand_stage.md
DELAYED_OPERAND_STAGE -- requirements
Module: delayed_operand_stage

Interface
REQ-001 SHALL have parameter FWD_PORTS, 2, number of writeback forwarding ports; port FWD_PORTS-1 is youngest.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush  input  1  kill held instruction.
REQ-005 SHALL have port stall  input  1  downstream delayed_exec stage holding.
REQ-006 SHALL have port in_valid  input  1  upstream presents a delayed-exec instruction.
REQ-007 SHALL have port data_in  input  $bits(pipeline_exec_t)  instruction bundle from exec stage.
REQ-008 SHALL have port src_addr  input  2x5  register addresses of operand 0 and operand 1.
REQ-009 SHALL have port src_ready  input  2  operand already valid in data_in.delayed_reg[i].
REQ-010 SHALL have port fwd  input  FWD_PORTS x fwd_port_t  writeback bypass {we, waddr[4:0], wdata[31:0]}.
REQ-011 SHALL have port out_valid  output  1  data_out has both operands resolved.
REQ-012 SHALL have port data_out  output  $bits(pipeline_exec_t)  bundle to delayed_exec, delayed_reg filled.
REQ-013 SHALL have port stall_req  output  1  request upstream hold while operands missing.
REQ-014 SHALL have port wait_cycles  output  32  operand-wait counter (only with DELAYED_OPERAND_PERF_EN).

Function
REQ-015 SHALL implement states EMPTY, WAIT, HOLD in a registered state variable.
REQ-016 SHALL capture data_in at a clock edge when in_valid & ~stall & ~stall_req & ~flush; latency one cycle.
REQ-017 SHALL mark operand i ready at capture if src_ready[i], src_addr[i]==0 (value forced 0), or a same-cycle fwd hit applies.
REQ-018 SHALL, on fwd[p].we & waddr==src_addr[i] & waddr!=0 for a not-ready operand, load wdata into delayed_reg[i] and set it ready; highest-index hitting port wins.
REQ-019 SHALL never overwrite an operand already ready.
REQ-020 SHALL transition EMPTY->HOLD on capture with both ready, EMPTY->WAIT on capture with either not ready.
REQ-021 SHALL transition WAIT->HOLD on the edge where the last missing operand is forwarded.
REQ-022 SHALL, in HOLD with ~stall, consume the entry: go HOLD on new capture (ready), WAIT (not ready), else EMPTY.
REQ-023 SHALL hold all registers unchanged in HOLD while stall=1.
REQ-024 SHALL drive out_valid=1 only in HOLD; stall_req=1 only in WAIT (combinational from state).
REQ-025 SHALL, on flush, go to EMPTY regardless of state, capture, forwarding or stall; flush has top priority.
REQ-026 SHALL drive data_out.decoded.delayed_exec = out_valid so delayed_exec resolves no branch from stale data.

Reset
REQ-027 SHALL on rst_n=0 asynchronously set state EMPTY, out_valid 0, stall_req 0, data_out all-zero, operand ready bits 0, wait_cycles 0.
REQ-028 SHALL discard any in-flight instruction on reset mid-WAIT or mid-HOLD; no output pulse on release.

Configuration
REQ-029 SHALL, with DELAYED_OPERAND_PERF_EN defined, increment wait_cycles by 1 per cycle in WAIT, saturating at 0xFFFFFFFF, never cleared except by reset.
REQ-030 SHALL, without DELAYED_OPERAND_PERF_EN, drive wait_cycles constant 0 and contain no counter register.

Structure
REQ-031 SHALL place fwd_port_t and the delayed_operand_state_t enum in the shared cpu_defs package.
REQ-032 SHALL use one sub-module delayed_bypass_mux per operand (priority select over fwd ports, register-0 handling).

Verification
REQ-033 SHALL test: capture with src_ready=2'b11, delayed_reg={5,7} -> next cycle out_valid=1, data_out.delayed_reg={5,7}, stall_req=0.
REQ-034 SHALL test: src_ready=2'b01, src_addr[1]=9; fwd[0]={1,9,0x1234} two cycles later -> stall_req high 2 cycles, then HOLD with delayed_reg[1]=0x1234, wait_cycles=2 (perf on).
REQ-035 SHALL test: fwd[0] and fwd[1] both write reg 9 same cycle (0xAAAA, 0xBBBB) -> delayed_reg[1]=0xBBBB.
REQ-036 SHALL test: HOLD with stall=1 for 3 cycles and new in_valid -> data_out unchanged, no capture; stall drop -> new entry captured.
REQ-037 SHALL test: flush asserted in WAIT with same-cycle matching fwd -> EMPTY, out_valid=0, stall_req=0.
REQ-038 SHALL test: src_addr[0]=0, src_ready=0 -> operand 0 reads 0, immediate HOLD; rst_n pulsed low in HOLD -> out_valid=0 asynchronously.
